// File: rtl/fir_l3_output_serializer.sv
// Buffers 3-sample FIR output blocks and emits them one sample per handshake,
// oldest block first, tagging each sample with its position in the block.
module fir_l3_output_serializer #(
    parameter int DATA_WIDTH  = 64,
    parameter int BLOCK_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data_1,
    input  logic signed [DATA_WIDTH-1:0] in_data_2,
    input  logic signed [DATA_WIDTH-1:0] in_data_3,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [1:0]                   out_phase,
    output logic                         out_last
);

    localparam int PTR_W = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic signed [DATA_WIDTH-1:0] mem_1 [BLOCK_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_2 [BLOCK_DEPTH];
    logic signed [DATA_WIDTH-1:0] mem_3 [BLOCK_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       phase;

    logic push;
    logic pop_beat;
    logic pop_block;

    // in_ready is forced low while reset is held so nothing is taken during reset.
    assign in_ready  = !reset && (count < CNT_W'(BLOCK_DEPTH));
    assign out_valid = (count != '0);
    assign out_phase = phase;
    assign out_last  = out_valid && (phase == 2'd2);

    assign push      = in_valid && in_ready;
    assign pop_beat  = out_valid && out_ready;
    assign pop_block = pop_beat && (phase == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            phase  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_block) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop_block})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop_beat) begin
                phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
            end
        end
    end

    // Sample storage needs no reset: it is only observed while count > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_1[wr_ptr] <= in_data_1;
            mem_2[wr_ptr] <= in_data_2;
            mem_3[wr_ptr] <= in_data_3;
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (phase)
                2'd0:    out_data = mem_1[rd_ptr];
                2'd1:    out_data = mem_2[rd_ptr];
                2'd2:    out_data = mem_3[rd_ptr];
                default: out_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_l3_output_serializer.sv
// Testbench for fir_l3_output_serializer: directed scenarios plus randomized
// streaming checked against a sample-queue reference model.
module tb_fir_l3_output_serializer;

    localparam int DW    = 64;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_last;
    logic [1:0] out_phase;
    logic signed [DW-1:0] in_data_1 = '0;
    logic signed [DW-1:0] in_data_2 = '0;
    logic signed [DW-1:0] in_data_3 = '0;
    logic signed [DW-1:0] out_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fir_l3_output_serializer #(.DATA_WIDTH(DW), .BLOCK_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_phase (out_phase),
        .out_last  (out_last)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic signed [DW-1:0] a, b, c);
        in_valid  = 1'b1;
        in_data_1 = a;
        in_data_2 = b;
        in_data_3 = c;
        cycle();
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        in_data_3 = '0;
    endtask

    function automatic logic signed [DW-1:0] pick();
        logic signed [DW-1:0] smin;
        smin = {1'b1, {(DW-1){1'b0}}};
        case ($urandom_range(0, 7))
            0:       return smin;
            1:       return ~smin;
            2:       return -1;
            default: return DW'({$urandom(), $urandom()});
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        in_data_1 = 123;
        repeat (3) cycle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        vectors++; if (out_phase !== 2'd0) begin miscompares++; $display("FAIL reset_out_phase: got %0d want 0", out_phase); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        in_data_1 = '0;
        reset = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
        cycle();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_in_ready2: got %b want 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_single_block();
        logic signed [DW-1:0] exp_d [3];
        exp_d = '{10, -20, 30};
        out_ready = 1'b1;
        push_block(10, -20, 30);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++; if (out_data !== exp_d[i]) begin miscompares++; $display("FAIL single_data[%0d]: got %0d want %0d", i, out_data, exp_d[i]); end
            vectors++; if (out_phase !== 2'(i)) begin miscompares++; $display("FAIL single_phase[%0d]: got %0d want %0d", i, out_phase, i); end
            vectors++; if (out_last !== (i == 2)) begin miscompares++; $display("FAIL single_last[%0d]: got %b want %b", i, out_last, (i == 2)); end
            cycle();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_end_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL single_end_data: got %0d want 0", out_data); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        push_block(1, 2, 3);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++; if (out_data !== 1) begin miscompares++; $display("FAIL bp_hold_data[%0d]: got %0d want 1", i, out_data); end
            vectors++; if (out_phase !== 2'd0) begin miscompares++; $display("FAIL bp_hold_phase[%0d]: got %0d want 0", i, out_phase); end
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_data !== DW'(i + 1)) begin miscompares++; $display("FAIL bp_release_data[%0d]: got %0d want %0d", i, out_data, i + 1); end
            vectors++; if (out_phase !== 2'(i)) begin miscompares++; $display("FAIL bp_release_phase[%0d]: got %0d want %0d", i, out_phase, i); end
            cycle();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        push_block(1, 2, 3);
        push_block(4, 5, 6);
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1;
        in_data_1 = 7; in_data_2 = 8; in_data_3 = 9;
        cycle();
        in_valid = 1'b0;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready2: got %b want 0", in_ready); end
        vectors++; if (out_data !== 1) begin miscompares++; $display("FAIL full_head: got %0d want 1", out_data); end
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            vectors++; if (out_data !== DW'(i)) begin miscompares++; $display("FAIL full_drain_data[%0d]: got %0d want %0d", i, out_data, i); end
            vectors++; if (in_ready !== (i >= 4)) begin miscompares++; $display("FAIL full_drain_ready[%0d]: got %b want %b", i, in_ready, (i >= 4)); end
            cycle();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_c_rejected: got valid %b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        push_block(1, 2, 3);
        push_block(4, 5, 6);
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL simul_valid[%0d]: got %b want 1", i, out_valid); end
            vectors++; if (out_data !== DW'(i)) begin miscompares++; $display("FAIL simul_data[%0d]: got %0d want %0d", i, out_data, i); end
            if (i == 4) begin
                vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL simul_in_ready: got %b want 1", in_ready); end
                in_valid = 1'b1;
                in_data_1 = 7; in_data_2 = 8; in_data_3 = 9;
            end
            cycle();
            in_valid = 1'b0;
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL simul_end_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_block();
        out_ready = 1'b1;
        push_block(1, 2, 3);
        cycle();
        cycle();
        vectors++; if (out_data !== 3) begin miscompares++; $display("FAIL rmid_pre_data: got %0d want 3", out_data); end
        reset = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL rmid_data: got %0d want 0", out_data); end
        vectors++; if (out_phase !== 2'd0) begin miscompares++; $display("FAIL rmid_phase: got %0d want 0", out_phase); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
        cycle();
        reset = 1'b0;
        push_block(4, 5, 6);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_data !== DW'(i + 4)) begin miscompares++; $display("FAIL rmid_after_data[%0d]: got %0d want %0d", i, out_data, i + 4); end
            vectors++; if (out_phase !== 2'(i)) begin miscompares++; $display("FAIL rmid_after_phase[%0d]: got %0d want %0d", i, out_phase, i); end
            cycle();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_end_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic signed [DW-1:0] q [$];
        logic signed [DW-1:0] d [3];
        logic [1:0] exp_phase;
        int blocks;
        bit push, pop;
        int budget;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            // A partly emitted block still occupies a slot.
            blocks = (q.size() + 2) / 3;
            exp_phase = 2'((3 - (q.size() % 3)) % 3);
            vectors++; if (out_valid !== (q.size() > 0)) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want %b", cyc, out_valid, (q.size() > 0)); end
            vectors++; if (in_ready !== (blocks < DEPTH)) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want %b", cyc, in_ready, (blocks < DEPTH)); end
            if (q.size() > 0) begin
                vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL stream_data[%0d]: got %0d want %0d", cyc, out_data, q[0]); end
                vectors++; if (out_phase !== exp_phase) begin miscompares++; $display("FAIL stream_phase[%0d]: got %0d want %0d", cyc, out_phase, exp_phase); end
                vectors++; if (out_last !== (exp_phase == 2'd2)) begin miscompares++; $display("FAIL stream_last[%0d]: got %b want %b", cyc, out_last, (exp_phase == 2'd2)); end
            end else begin
                vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL stream_idle_data[%0d]: got %0d want 0", cyc, out_data); end
                vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL stream_idle_last[%0d]: got %b want 0", cyc, out_last); end
            end
            for (int k = 0; k < 3; k++) d[k] = pick();
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data_1 = d[0];
            in_data_2 = d[1];
            in_data_3 = d[2];
            out_ready = ($urandom_range(0, 99) < 65);
            push = in_valid && (blocks < DEPTH);
            pop  = (q.size() > 0) && out_ready;
            cycle();
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(d[0]);
                q.push_back(d[1]);
                q.push_back(d[2]);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 3 * DEPTH + 3;
        while (q.size() > 0 && budget > 0) begin
            vectors++; if (out_data !== q[0]) begin miscompares++; $display("FAIL drain_data: got %0d want %0d", out_data, q[0]); end
            cycle();
            void'(q.pop_front());
            budget--;
        end
        vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL drain_timeout: %0d samples left want 0", q.size()); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_end_valid: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_backpressure();
        test_full();
        test_simultaneous();
        test_reset_mid_block();
        test_streaming();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fir_l3_output_serializer.md
FIR_L3_OUTPUT_SERIALIZER -- requirements
Module: fir_l3_output_serializer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 64, giving the width of each filtered sample.
REQ-002 The module SHALL have parameter BLOCK_DEPTH, default 2, giving the number of 3-sample blocks buffered (power of two, >=2).
REQ-003 The module SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The module SHALL have port in_valid  input  1  a 3-sample block is presented.
REQ-006 The module SHALL have port in_ready  output  1  the block buffer can accept a block.
REQ-007 The module SHALL have ports in_data_1, in_data_2, in_data_3  input  DATA_WIDTH signed each  filter outputs y(3k), y(3k+1), y(3k+2).
REQ-008 The module SHALL have port out_valid  output  1  out_data holds a valid serial sample.
REQ-009 The module SHALL have port out_ready  input  1  the downstream sink accepts the sample.
REQ-010 The module SHALL have port out_data  output  DATA_WIDTH signed  serial output sample.
REQ-011 The module SHALL have port out_phase  output  2  index of the current sample within its block (0, 1, 2).
REQ-012 The module SHALL have port out_last  output  1  high when out_phase==2 and out_valid==1.

Function
REQ-013 The module SHALL accept a block when in_valid && in_ready are high on a rising clk edge, storing all three samples unmodified (no width change, no arithmetic).
REQ-014 The module SHALL drive in_ready = 1 exactly when the stored block count < BLOCK_DEPTH, independent of out_ready (no pass-through when full).
REQ-015 The module SHALL drive out_valid = 1 exactly when the stored block count > 0.
REQ-016 The module SHALL drive out_data from the oldest stored block: in_data_1 at phase 0, in_data_2 at phase 1, in_data_3 at phase 2; out_data SHALL be 0 when out_valid is 0.
REQ-017 The module SHALL advance the phase counter 0->1->2->0 only on a cycle with out_valid && out_ready, and hold it otherwise.
REQ-018 The module SHALL release the oldest block on the handshake cycle at phase 2, returning the phase counter to 0.
REQ-019 The module SHALL keep out_data, out_phase and out_valid stable while out_valid && !out_ready.
REQ-020 The module SHALL allow a push and a phase-2 pop in the same cycle, leaving the count unchanged and keeping FIFO order.
REQ-021 The module SHALL present a block pushed into an empty buffer on out_data in the cycle after the push edge, which gives a latency of 1 clk.
REQ-022 The module SHALL sustain 3 output samples per accepted block, and at most one block per 3 cycles once the buffer is full.
REQ-023 The module SHALL use read/write pointers that wrap modulo BLOCK_DEPTH and a count from 0 to BLOCK_DEPTH, with no overflow or underflow under legal handshakes.
REQ-024 The module SHALL ignore in_data_* when in_valid is 0 or in_ready is 0.

Reset
REQ-025 While reset is high the module SHALL hold count=0, pointers=0, phase=0, out_valid=0, out_data=0, out_last=0, out_phase=0 and in_ready=0.
REQ-026 The module SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-027 The module SHALL discard any buffered or partly emitted block when reset asserts mid-operation, and restart at phase 0 with the next accepted block.

Verification
REQ-028 Single block: push (10, -20, 30) with out_ready=1 -> out_data 10, -20, 30 on the next 3 cycles; out_phase 0, 1, 2; out_last only on 30; then out_valid=0.
REQ-029 Backpressure: push (1, 2, 3), out_ready=0 for 5 cycles -> out_data held at 1 with phase 0; release -> 1, 2, 3 in order.
REQ-030 Full: out_ready=0, push blocks A=(1,2,3) and B=(4,5,6) -> in_ready=0 and block C is not accepted; drain -> 1..6 in order, and in_ready rises on the cycle after 3 pops.
REQ-031 Simultaneous: buffer full, out_ready=1; on the phase-2 edge of A the next cycle offers C=(7,8,9) -> C accepted after in_ready=1; output stream 1..9 contiguous with no bubble.
REQ-032 Reset mid-block: assert reset after sample 2 of (1, 2, 3) -> outputs zero at once; after release push (4, 5, 6) -> 4, 5, 6 with phase starting at 0.
REQ-033 Streaming: continuous random blocks, random out_ready -> output sequence equals the input concatenation, and signed extremes (-2^(DATA_WIDTH-1)) pass through bit-exact.
